// File: rtl/mux8_arb_pkg.sv
// Shared types and helpers for the eight-way round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int NREQ = 8;
    localparam int SELW = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // First set request bit at or above ptr, wrapping modulo NREQ.
    function automatic logic [SELW-1:0] next_req(input logic [NREQ-1:0] req,
                                                 input logic [SELW-1:0] ptr);
        logic [SELW-1:0] idx;
        logic            found;
        next_req = ptr;
        found    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr + SELW'(i);
            if (!found && req[idx]) begin
                next_req = idx;
                found    = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Requester/consumer bundle for mux8_rr_arbiter: eight producers in, one valid/ready channel out.
interface mux8_rr_arbiter_if
    import mux8_arb_pkg::*;
#(
    parameter int N = 4
);
    logic [NREQ-1:0] req;
    logic [N-1:0]    d0, d1, d2, d3, d4, d5, d6, d7;
    logic [NREQ-1:0] ack;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_data;
    logic [SELW-1:0] out_src;

    modport master (
        output req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
        input  ack, out_valid, out_data, out_src
    );

    modport slave (
        input  req, d0, d1, d2, d3, d4, d5, d6, d7, out_ready,
        output ack, out_valid, out_data, out_src
    );

endinterface

// File: rtl/mux8_rr_arbiter_mux8.sv
// Plain 8-to-1 N-bit combinational multiplexer.
module mux8 #(
    parameter int N = 4
) (
    input  logic [2:0]   select,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic [N-1:0] d4,
    input  logic [N-1:0] d5,
    input  logic [N-1:0] d6,
    input  logic [N-1:0] d7,
    output logic [N-1:0] exit
);

    always_comb begin
        exit = d0;
        case (select)
            3'd0: exit = d0;
            3'd1: exit = d1;
            3'd2: exit = d2;
            3'd3: exit = d3;
            3'd4: exit = d4;
            3'd5: exit = d5;
            3'd6: exit = d6;
            3'd7: exit = d7;
            default: exit = d0;
        endcase
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8-to-1 mux among eight requesters.
// Define ARB_HOLD_LIMIT_EN to force release after HOLD beats per grant.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int HOLD = 4
) (
    input logic              clk,
    input logic              reset,
    mux8_rr_arbiter_if.slave bus
);

    if (HOLD < 1) begin : g_bad_hold
        $error("mux8_rr_arbiter: HOLD must be at least 1");
    end

    arb_state_t      state;
    logic [SELW-1:0] sel;
    logic [SELW-1:0] ptr;
    logic            req_sel;
    logic            xfer;
    logic            at_limit;
    logic            release_now;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(HOLD + 1);
    logic [CW-1:0] cnt;
    assign at_limit = (cnt == CW'(HOLD - 1));
`else
    assign at_limit = 1'b0;
`endif

    assign req_sel       = bus.req[sel];
    assign bus.out_valid = (state == GRANT) && req_sel;
    assign xfer          = bus.out_valid && bus.out_ready;
    assign bus.ack       = xfer ? (NREQ'(1) << sel) : '0;
    assign bus.out_src   = sel;

    // A dropped request releases without a beat; a limit beat releases after transferring.
    assign release_now = (state == GRANT) && (!req_sel || (xfer && at_limit));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        sel   <= next_req(bus.req, ptr);
                        state <= GRANT;
`ifdef ARB_HOLD_LIMIT_EN
                        cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state <= IDLE;
                        ptr   <= sel + 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
                        cnt   <= '0;
`endif
                    end
`ifdef ARB_HOLD_LIMIT_EN
                    else if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    mux8 #(.N(N)) u_mux (
        .select (sel),
        .d0     (bus.d0),
        .d1     (bus.d1),
        .d2     (bus.d2),
        .d3     (bus.d3),
        .d4     (bus.d4),
        .d5     (bus.d5),
        .d6     (bus.d6),
        .d7     (bus.d7),
        .exit   (bus.out_data)
    );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_mux8_rr_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int OW   = 1 + 8 + 3 + N;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] dv [8];
    int           checks   = 0;
    int           failures = 0;

    // Model: who owns the mux, where the search starts next, beats moved this grant.
    bit m_granted;
    int m_owner;
    int m_next;
    int m_beats;

    always #5 clk = ~clk;

    mux8_rr_arbiter_if #(.N(N)) bus ();

    assign bus.d0 = dv[0];
    assign bus.d1 = dv[1];
    assign bus.d2 = dv[2];
    assign bus.d3 = dv[3];
    assign bus.d4 = dv[4];
    assign bus.d5 = dv[5];
    assign bus.d6 = dv[6];
    assign bus.d7 = dv[7];

    mux8_rr_arbiter #(.N(N), .HOLD(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [OW-1:0] obs();
        return {bus.out_valid, bus.ack, bus.out_src, bus.out_data};
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        logic       v;
        logic [7:0] a;
        v = m_granted && bus.req[m_owner];
        a = (v && bus.out_ready) ? 8'(1 << m_owner) : 8'h00;
        return {v, a, 3'(m_owner), dv[m_owner]};
    endfunction

    // Advance the model by one rising edge using the inputs held across that edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_granted = 0; m_owner = 0; m_next = 0; m_beats = 0;
        end else if (!m_granted) begin
            if (bus.req != 8'h00) begin
                for (int k = 7; k >= 0; k--)
                    if (bus.req[(m_next + k) % 8]) m_owner = (m_next + k) % 8;
                m_beats   = 0;
                m_granted = 1;
            end
        end else if (!bus.req[m_owner]) begin
            m_granted = 0;
            m_next    = (m_owner + 1) % 8;
        end else if (bus.out_ready) begin
            m_beats++;
            if (LIMIT && m_beats == HOLD) begin
                m_granted = 0;
                m_next    = (m_owner + 1) % 8;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.req = 8'hFF; bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (obs() !== {1'b0, 8'h00, 3'd0, dv[0]}) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs(), {1'b0, 8'h00, 3'd0, dv[0]});
            end
            tick();
        end
        reset = 1'b0;
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle got=%b exp=0", bus.out_valid);
        end
        tick();
        #2;
        checks++;
        if ({bus.out_valid, bus.out_src, bus.ack} !== {1'b1, 3'd0, 8'h01}) begin
            failures++;
            $display("FAIL reset_first_grant got=%h exp=%h", {bus.out_valid, bus.out_src, bus.ack}, {1'b1, 3'd0, 8'h01});
        end
        tick();
    endtask

    task automatic test_single();
        logic [13:0] vseq;
        logic [13:0] vexp;
        do_reset();
        bus.req = 8'h08; bus.out_ready = 1'b1; dv[3] = 4'hA;
        for (int i = 0; i < 14; i++) begin
            #2;
            vseq[13-i] = bus.out_valid;
            checks++;
            if (obs() !== exp_vec()) begin
                failures++;
                $display("FAIL single cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
            end
            if (bus.out_valid) begin
                checks++;
                if ({bus.out_src, bus.ack, bus.out_data} !== {3'd3, 8'h08, 4'hA}) begin
                    failures++;
                    $display("FAIL single_beat cyc=%0d got=%h exp=%h", i, {bus.out_src, bus.ack, bus.out_data}, {3'd3, 8'h08, 4'hA});
                end
            end
            tick();
        end
`ifdef ARB_HOLD_LIMIT_EN
        vexp = 14'b01111011110111;
`else
        vexp = 14'b01111111111111;
`endif
        checks++;
        if (vseq !== vexp) begin
            failures++;
            $display("FAIL single_valid_pattern got=%b exp=%b", vseq, vexp);
        end
    endtask

    task automatic test_rotation();
        int order[$];
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && order.size() < 9; i++) begin
            bus.req = 8'hFF;
            if (m_granted && m_beats >= 1) bus.req[m_owner] = 1'b0;
            #2;
            checks++;
            if (obs() !== exp_vec()) begin
                failures++;
                $display("FAIL rotation cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
            end
            if (bus.ack != 8'h00) order.push_back(int'(bus.out_src));
            tick();
        end
        checks++;
        if (order.size() < 9) begin
            failures++;
            $display("FAIL rotation_count got=%0d exp=9", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            checks++;
            if (order[i] != i % 8) begin
                failures++;
                $display("FAIL rotation_order idx=%0d got=%0d exp=%0d", i, order[i], i % 8);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        bus.req = 8'h20; bus.out_ready = 1'b0;
        tick();
        #2;
        checks++;
        if ({bus.out_valid, bus.out_src} !== {1'b1, 3'd5}) begin
            failures++;
            $display("FAIL drop_grant got=%h exp=%h", {bus.out_valid, bus.out_src}, {1'b1, 3'd5});
        end
        bus.req = 8'h00; bus.out_ready = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.ack} !== 9'h000) begin
            failures++;
            $display("FAIL drop_no_ack got=%h exp=000", {bus.out_valid, bus.ack});
        end
        tick();
        #2;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_idle got=%b exp=0", bus.out_valid);
        end
        bus.req = 8'hFF;
        tick();
        #2;
        checks++;
        if ({bus.out_valid, bus.out_src} !== {1'b1, 3'd6}) begin
            failures++;
            $display("FAIL drop_next_ptr got=%h exp=%h", {bus.out_valid, bus.out_src}, {1'b1, 3'd6});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.req = 8'h80; bus.out_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            #2;
            checks++;
            if ({bus.out_valid, bus.ack, bus.out_src} !== {1'b1, 8'h00, 3'd7}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, {bus.out_valid, bus.ack, bus.out_src}, {1'b1, 8'h00, 3'd7});
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < HOLD; i++) begin
            #2;
            checks++;
            if (obs() !== exp_vec() || bus.ack !== 8'h80) begin
                failures++;
                $display("FAIL bp_beat cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
            end
            tick();
        end
        #2;
        checks++;
`ifdef ARB_HOLD_LIMIT_EN
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_limit_release got=%b exp=0", bus.out_valid);
        end
`else
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_no_limit got=%b exp=1", bus.out_valid);
        end
`endif
        bus.req = 8'h00;
        tick();
        bus.req = 8'h81;
        #2;
        checks++;
        if (obs() !== exp_vec()) begin
            failures++;
            $display("FAIL bp_idle got=%h exp=%h", obs(), exp_vec());
        end
        tick();
        #2;
        checks++;
        if ({bus.out_valid, bus.out_src} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL bp_wrap got=%h exp=%h", {bus.out_valid, bus.out_src}, {1'b1, 3'd0});
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.req = 8'h04; bus.out_ready = 1'b1;
        tick();
        tick();
        #2;
        checks++;
        if ({bus.out_valid, bus.ack} !== {1'b1, 8'h04}) begin
            failures++;
            $display("FAIL midrst_beat got=%h exp=%h", {bus.out_valid, bus.ack}, {1'b1, 8'h04});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        checks++;
        if (obs() !== {1'b0, 8'h00, 3'd0, dv[0]}) begin
            failures++;
            $display("FAIL midrst_values got=%h exp=%h", obs(), {1'b0, 8'h00, 3'd0, dv[0]});
        end
        tick();
    endtask

    task automatic test_long_hold();
        do_reset();
        bus.req = 8'h10; bus.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            #2;
            checks++;
            if (obs() !== exp_vec()) begin
                failures++;
                $display("FAIL long_hold cyc=%0d got=%h exp=%h", i, obs(), exp_vec());
            end
`ifndef ARB_HOLD_LIMIT_EN
            checks++;
            if (bus.ack !== 8'h10) begin
                failures++;
                $display("FAIL long_hold_ack cyc=%0d got=%h exp=10", i, bus.ack);
            end
`endif
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: bus.req = 8'(1 << $urandom_range(0, 7));
                1: bus.req = 8'h00;
                default: bus.req = 8'($urandom);
            endcase
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 8; k++) dv[k] = N'($urandom);
            reset = ($urandom_range(0, 63) == 0);
            #2;
            checks++;
            if (obs() !== exp_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d req=%h rdy=%b got=%h exp=%h", i, bus.req, bus.out_ready, obs(), exp_vec());
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        m_granted = 0; m_owner = 0; m_next = 0; m_beats = 0;
        reset = 1'b1; bus.req = 8'h00; bus.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) dv[k] = N'(k + 1);
        #1;
        test_reset();
        test_single();
        test_rotation();
        test_drop();
        test_backpressure();
        test_mid_reset();
        test_long_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
